// File: rtl/dw_asymfifo_push_arb.sv
// dw_asymfifo_push_arb: round-robin push arbiter that locks the grant for one packed FIFO word; define ASYMARB_GRANT_CNT_EN for per-requester group counters
module dw_asymfifo_push_arb #(
  parameter int num_req = 4,
  parameter int data_in_width = 8,
  parameter int data_out_width = 32,
  parameter int tmo_cycles = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [num_req-1:0]                 req_n,
  input  logic [num_req*data_in_width-1:0]   req_data,
  output logic [num_req-1:0]                 gnt,
  input  logic                               fifo_full,
  input  logic                               fifo_part_wd,
  output logic                               fifo_push_req_n,
  output logic                               fifo_flush_n,
  output logic [data_in_width-1:0]           fifo_data_in,
  output logic                               flush_evt
`ifdef ASYMARB_GRANT_CNT_EN
  ,
  output logic [num_req*16-1:0]              grant_cnt
`endif
);
  localparam int K = data_out_width > data_in_width ? data_out_width / data_in_width : 1;
  localparam int CW = $clog2(K) + 1;
  localparam int IW = num_req > 1 ? $clog2(num_req) : 1;
  typedef enum logic [1:0] {IDLE, LOCK, FLUSH} state_t;
  state_t state, state_nxt;
  logic [num_req-1:0] gnt_nxt;
  logic [IW-1:0] rr, rr_nxt, owner, owner_nxt, owner_inc, win, idx;
  logic [CW-1:0] beat_cnt, beat_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic found, push, last_beat, rel;
  assign push = state == LOCK && !req_n[owner] && !fifo_full;
  assign last_beat = beat_cnt == CW'(K - 1);
  assign owner_inc = IW'((int'(owner) + 1) % num_req);
  assign fifo_push_req_n = !push;
  assign flush_evt = state == FLUSH && !fifo_full;
  assign fifo_flush_n = !flush_evt;
  assign rel = (state == LOCK && (push ? last_beat : req_n[owner] && beat_cnt == '0)) || flush_evt;
  // first requester at or above rr, wrapping
  always_comb begin
    found = 1'b0;
    win = rr;
    idx = rr;
    for (int i = 0; i < num_req; i++) begin
      idx = IW'((int'(rr) + i) % num_req);
      if (!found && !req_n[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // one-hot mux of the owner's slice; zero while no grant is held
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < num_req; i++)
      fifo_data_in = fifo_data_in | (req_data[i*data_in_width +: data_in_width] & {data_in_width{gnt[i]}});
  end
  // grant lock, beat counting, idle timeout and hand-off after a group or flush
  always_comb begin
    state_nxt = state;
    gnt_nxt = gnt;
    rr_nxt = rr;
    owner_nxt = owner;
    beat_nxt = beat_cnt;
    tmo_nxt = tmo_cnt;
    case (state)
      IDLE: if (found) begin
        state_nxt = LOCK;
        gnt_nxt = '0;
        gnt_nxt[win] = 1'b1;
        owner_nxt = win;
        beat_nxt = '0;
        tmo_nxt = '0;
      end
      LOCK: if (push) begin
        beat_nxt = beat_cnt + 1'b1;
        tmo_nxt = '0;
      end else if (req_n[owner] && beat_cnt != '0) begin
        tmo_nxt = tmo_cnt + 1'b1;
        state_nxt = int'(tmo_cnt) + 2 >= tmo_cycles ? FLUSH : LOCK;
      end
      default: ;
    endcase
    if (rel) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      beat_nxt = '0;
      rr_nxt = owner_inc;
    end
  end
  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      rr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      rr <= rr_nxt;
      owner <= owner_nxt;
      beat_cnt <= beat_nxt;
      tmo_cnt <= tmo_nxt;
    end
`ifdef ASYMARB_GRANT_CNT_EN
  logic done;
  assign done = (push && last_beat) || flush_evt;
  // saturating count of committed groups per requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grant_cnt <= '0;
    else
      for (int i = 0; i < num_req; i++)
        if (done && owner == IW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
`endif
  // a half-built word must never outlive a grant, and a flush must have one to commit
  always @(posedge clk)
    if (rst_n) assert ((state != IDLE || !fifo_part_wd) && (state != FLUSH || fifo_part_wd));
endmodule

// File: tb/tb_dw_asymfifo_push_arb.sv
// tb_dw_asymfifo_push_arb: directed and random checks of the push arbiter against a behavioural model with a packing-FIFO model
module tb_dw_asymfifo_push_arb;
  localparam int N = 4, DW = 8, K = 4, TMO = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_n = '1, gnt;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_full = 1'b0, fifo_part_wd = 1'b0, fifo_push_req_n, fifo_flush_n, flush_evt;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] req2_n = '1, gnt2;
  logic [31:0] req2_data = '0;
  logic push2_n, flush2_n, evt2;
  logic [15:0] data2;
`ifdef ASYMARB_GRANT_CNT_EN
  logic [N*16-1:0] gc;
  logic [31:0] gc2;
`endif
  int n_pass = 0, n_tot = 0, n_fail = 0;
  int m_own = -1, m_mode = 0, m_beats = 0, m_idle = 0, m_next = 0;
  logic [DW-1:0] pend[$];
  logic [31:0] words[$];
  int order[$];
  logic [N-1:0] s_gnt = '0;
  logic s_acc = 1'b0, s_evt = 1'b0, s_pushn = 1'b1;
  int k, n, cnt_a, cnt_b, tot, hold;
  int bcnt[N];
  logic [N-1:0] pat;
  logic [1:0] e2;
  logic [7:0] t1[8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  dw_asymfifo_push_arb dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_part_wd(fifo_part_wd), .fifo_push_req_n(fifo_push_req_n),
    .fifo_flush_n(fifo_flush_n), .fifo_data_in(fifo_data_in), .flush_evt(flush_evt)
`ifdef ASYMARB_GRANT_CNT_EN
    , .grant_cnt(gc)
`endif
  );

  dw_asymfifo_push_arb #(.num_req(2), .data_in_width(16), .data_out_width(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_n(req2_n), .req_data(req2_data), .gnt(gnt2),
    .fifo_full(1'b0), .fifo_part_wd(1'b0), .fifo_push_req_n(push2_n),
    .fifo_flush_n(flush2_n), .fifo_data_in(data2), .flush_evt(evt2)
`ifdef ASYMARB_GRANT_CNT_EN
    , .grant_cnt(gc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ord(input int i);
    return i < order.size() ? order[i] : -1;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return i < words.size() ? words[i] : 32'hxxxxxxxx;
  endfunction

  task automatic commit();
    logic [31:0] w = '0;
    foreach (pend[i]) w[i*8 +: 8] = pend[i];
    words.push_back(w);
    pend.delete();
  endtask

  task automatic rel();
    m_next = (m_own + 1) % N;
    m_own = -1;
    m_mode = 0;
  endtask

  // one clock: check outputs against the model mid-cycle, then advance model and FIFO after the edge
  task automatic step();
    logic [N-1:0] eg;
    logic ep, ef, fl;
    logic [DW-1:0] ed, d;
    #1;
    eg = m_own < 0 ? '0 : N'(1) << m_own;
    ep = m_mode == 1 && !req_n[m_own] && !fifo_full;
    ed = m_own < 0 ? '0 : req_data[m_own*DW +: DW];
    ef = m_mode == 2 && !fifo_full;
    chk("gnt", gnt, eg);
    chk("push_req_n", fifo_push_req_n, !ep);
    chk("data_in", fifo_data_in, ed);
    chk("flush_n", fifo_flush_n, !ef);
    chk("flush_evt", flush_evt, ef);
    s_acc = !fifo_push_req_n && !fifo_full;
    s_evt = flush_evt;
    s_pushn = fifo_push_req_n;
    fl = !fifo_flush_n;
    d = fifo_data_in;
    if (gnt != '0 && s_gnt == '0) order.push_back($clog2(gnt));
    s_gnt = gnt;
    @(posedge clk);
    #1;
    if (s_acc) pend.push_back(d);
    if ((fl && pend.size() > 0) || pend.size() == K) commit();
    fifo_part_wd = pend.size() != 0;
    case (m_mode)
      0: for (int i = 0; i < N; i++)
        if (m_mode == 0 && !req_n[(m_next + i) % N]) begin
          m_own = (m_next + i) % N;
          m_mode = 1;
          m_beats = 0;
          m_idle = 0;
        end
      1: if (ep) begin
        m_beats++;
        m_idle = 0;
        if (m_beats == K) rel();
      end else if (req_n[m_own]) begin
        if (m_beats == 0) rel();
        else begin
          m_idle++;
          if (m_idle >= TMO - 1) m_mode = 2;
        end
      end
      default: if (ef) rel();
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_own = -1; m_mode = 0; m_beats = 0; m_idle = 0; m_next = 0;
    pend.delete(); words.delete(); order.delete();
    s_gnt = '0; fifo_part_wd = 1'b0; fifo_full = 1'b0; req_n = '1; req2_n = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_gnt", gnt, 0);
    chk("reset_push_req_n", fifo_push_req_n, 1);
    chk("reset_flush_n", fifo_flush_n, 1);
    chk("reset_flush_evt", flush_evt, 0);
    chk("reset_gnt2", gnt2, 0);
    do_reset();
    // single requester, two full words
    req_n = 4'b1110;
    k = 0;
    for (n = 0; n < 60 && k < 8; n++) begin
      req_data[7:0] = t1[k];
      step();
      if (n == 1) chk("t1_grant_latency", s_gnt, 4'b0001);
      if (s_acc) k++;
    end
    chk("t1_beats", k, 8);
    req_n = '1;
    repeat (3) step();
    chk("t1_words", words.size(), 2);
    chk("t1_word0", wd(0), 32'hDDCCBBAA);
    chk("t1_word1", wd(1), 32'h44332211);
    // all four requesting continuously
    do_reset();
    foreach (bcnt[i]) bcnt[i] = 0;
    req_n = '0;
    tot = 0;
    for (n = 0; n < 120 && tot < 20; n++) begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {4'(i), 4'(bcnt[i])};
      step();
      if (s_acc) begin
        bcnt[$clog2(s_gnt)]++;
        tot++;
      end
    end
    chk("t2_pushes", tot, 20);
    req_n = '1;
    repeat (3) step();
    for (int i = 0; i < 5; i++) chk("t2_order", ord(i), i % N);
    for (int r = 0; r < N; r++) chk("t2_word", wd(r), {4'(r), 4'd3, 4'(r), 4'd2, 4'(r), 4'd1, 4'(r), 4'd0});
    // abandoned partial group
    do_reset();
    req_n = 4'b1011;
    k = 0;
    for (n = 0; n < 20 && k < 2; n++) begin
      req_data[23:16] = 8'h50 + 8'(k);
      step();
      if (s_acc) k++;
    end
    chk("t3_beats", k, 2);
    req_n = '1;
    for (n = 1; n <= 40; n++) begin
      step();
      if (s_evt) break;
    end
    chk("t3_flush_cycle", n, 16);
    req_n = 4'b0110;
    repeat (2) step();
    chk("t3_next_owner", ord(1), 3);
    chk("t3_words", words.size(), 1);
    chk("t3_partial_word", wd(0), 32'h00005150);
    req_n = '1;
    repeat (8) step();
    // back-pressure mid-group
    do_reset();
    req_n = 4'b1101;
    k = 0;
    for (n = 0; n < 20 && k < 2; n++) begin
      req_data[15:8] = 8'hC0 + 8'(k);
      step();
      if (s_acc) k++;
    end
    req_data[15:8] = 8'hC2;
    fifo_full = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      step();
      if (!s_pushn) cnt_a++;
      if (s_evt) cnt_b++;
    end
    chk("t4_no_push", cnt_a, 0);
    chk("t4_no_flush", cnt_b, 0);
    fifo_full = 1'b0;
    for (n = 0; n < 20 && k < 4; n++) begin
      req_data[15:8] = 8'hC0 + 8'(k);
      step();
      if (s_acc) k++;
    end
    chk("t4_beats", k, 4);
    req_n = '1;
    repeat (2) step();
    chk("t4_words", words.size(), 1);
    chk("t4_word0", wd(0), 32'hC3C2C1C0);
    // single-beat groups on the 16/16 instance
    do_reset();
    req2_n = 2'b00;
    cnt_b = 0;
    for (int c = 0; c < 12; c++) begin
      req2_data = {16'hB000 + 16'(c), 16'hA000 + 16'(c)};
      #1;
      e2 = c % 2 == 0 ? 2'b00 : ((c / 2) % 2 == 0 ? 2'b01 : 2'b10);
      chk("k1_gnt", gnt2, e2);
      chk("k1_push_n", push2_n, e2 == 2'b00);
      chk("k1_data", data2, e2 == 2'b00 ? 16'h0 : (e2 == 2'b01 ? 16'hA000 + 16'(c) : 16'hB000 + 16'(c)));
      if (evt2 || !flush2_n) cnt_b++;
      @(negedge clk);
    end
    chk("k1_no_flush", cnt_b, 0);
    req2_n = '1;
    // asynchronous reset in the middle of a group
    do_reset();
    req_n = 4'b1110;
    k = 0;
    for (n = 0; n < 20 && k < 2; n++) begin
      req_data[7:0] = 8'h70 + 8'(k);
      step();
      if (s_acc) k++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_push_req_n", fifo_push_req_n, 1);
    chk("arst_flush_n", fifo_flush_n, 1);
    do_reset();
    req_n = 4'b0000;
    repeat (2) step();
    chk("arst_first_grant", ord(0), 0);
    // random traffic with held patterns so owners sometimes abandon groups
    do_reset();
    hold = 0;
    pat = '1;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        pat = N'($urandom);
        hold = $urandom_range(1, 25);
      end
      hold--;
      req_n = $urandom_range(0, 7) == 0 ? N'($urandom) : pat;
      req_data = $urandom;
      fifo_full = $urandom_range(0, 4) == 0;
      step();
    end
    req_n = '1;
    fifo_full = 1'b0;
    repeat (40) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/dw_asymfifo_push_arb.md
Name: dw_asymfifo_push_arb

Overview:
- Round-robin arbiter that lets num_req narrow producers share the single push port of one DW_asymfifo_s1_df.
- With data_in_width < data_out_width the FIFO packs several input beats into one RAM word, so the grant is locked to one requester for a full group of K beats. Words are never built from mixed sources.
- If a requester abandons a partial group, a timeout issues a FIFO flush so the partial word is committed and the port is released.

Parameters:
- num_req, 4, number of requesters (2..16).
- data_in_width, 8, per-requester and FIFO input width.
- data_out_width, 32, FIFO output width. Must be an integer multiple of data_in_width, or less than or equal to it.
- tmo_cycles, 16, number of consecutive idle owner cycles before a partial-group flush (1..255).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_n  input  num_req  per-requester push request, active low.
- req_data  input  num_req*data_in_width  packed requester data; requester i occupies bits [i*data_in_width +: data_in_width].
- gnt  output  num_req  one-hot registered grant. A push from requester i is accepted in a cycle where gnt[i]=1, req_n[i]=0 and fifo_full=0.
- fifo_full  input  1  FIFO full flag.
- fifo_part_wd  input  1  FIFO part_wd flag; used for checking only.
- fifo_push_req_n  output  1  to FIFO push_req_n.
- fifo_flush_n  output  1  to FIFO flush_n.
- fifo_data_in  output  data_in_width  to FIFO data_in.
- flush_evt  output  1  one-cycle pulse when a timeout flush is issued.

Behaviour:
- Group size: K = data_out_width/data_in_width when data_out_width > data_in_width; otherwise K = 1. The beat counter is clog2(K)+1 bits wide.
- States:
  - IDLE: arbitrate among requesters with req_n low.
  - LOCK: grant held by one owner.
  - FLUSH: issuing a flush for an abandoned partial group.
- Reset values: state IDLE; gnt 0; rr pointer 0; beat_cnt 0; tmo_cnt 0; fifo_push_req_n 1; fifo_flush_n 1; flush_evt 0.
- IDLE:
  - Winner is the first requester with req_n low, searching from the rr pointer upward and wrapping modulo num_req.
  - On the next edge: gnt = onehot(winner), state LOCK, beat_cnt 0, tmo_cnt 0.
  - If no request is present, stay in IDLE with gnt 0.
  - Grant latency from request is 1 cycle.
- LOCK datapath (combinational):
  - fifo_push_req_n = ~(req_n[owner]==0 && !fifo_full).
  - fifo_data_in = req_data slice selected by gnt.
  - When gnt is 0, fifo_data_in is 0.
- LOCK, accepted push:
  - beat_cnt increments and tmo_cnt clears.
  - On the accepted push with beat_cnt == K-1: release. Next state IDLE, gnt 0, rr pointer = owner+1 mod num_req.
  - This gives one bubble cycle between owners.
- LOCK, fifo_full high with owner requesting: push is withheld and tmo_cnt holds. Back-pressure never counts as idle.
- LOCK, owner req_n high:
  - If beat_cnt == 0, release immediately (rr pointer advances as above).
  - Otherwise tmo_cnt increments. When tmo_cnt reaches tmo_cycles-1 while the owner is still idle, go to FLUSH.
  - The owner reasserting req_n clears tmo_cnt and its push proceeds normally.
- FLUSH:
  - gnt holds and fifo_push_req_n stays 1.
  - fifo_flush_n is driven low combinationally for exactly one cycle, the first FLUSH cycle with fifo_full == 0. flush_evt pulses in that same cycle.
  - Next edge: IDLE, gnt 0, beat_cnt 0, rr pointer advances.
  - While fifo_full is 1, stay in FLUSH with fifo_flush_n 1.
- K == 1: every accepted push releases the grant, giving pure per-beat round robin. The timeout path is unreachable.
- Invariant: when entering IDLE through release, fifo_part_wd == 0. When entering FLUSH, fifo_part_wd == 1.
- Reset mid-operation: all state clears asynchronously and the outputs return to their reset values. A partial word already held in the FIFO is the FIFO's concern and is cleared by its own reset.

Optional Feature:
- Macro: ASYMARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt, num_req*16 bits: one saturating 16-bit counter per requester.
  - Each counter increments on every completed or flushed group of that requester and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Test Plan:
- Defaults (K=4), req_n=4'b1110, 8 beats AA,BB,CC,DD,11,22,33,44 → gnt=0001 one cycle after the request. Two FIFO words, 32'hDDCCBBAA then 32'h44332211 (byte_order 0). One gnt=0 bubble after each group of 4 pushes.
- All four requesters request continuously, 4 beats each → grant order 0,1,2,3,0. Every FIFO word contains bytes from a single requester only.
- Requester 2 pushes 2 beats, then goes idle → flush_evt and fifo_flush_n low exactly on cycle 16 after the last push. Grant then passes to the next requester; the FIFO holds one partial word.
- Owner mid-group with fifo_full held high for 40 cycles → no push, no flush, tmo_cnt held at 0. The group completes after fifo_full drops.
- data_in_width=data_out_width=16, two requesters continuous → alternating single-push grants; flush_evt never asserts.
- rst_n pulsed low in LOCK with beat_cnt=2 → gnt=0, fifo_push_req_n=1 and fifo_flush_n=1 immediately without a clock edge. The first grant after reset goes to requester 0.
